ro_puf_eval: RTL and testbench

//  Parametrised ring-oscillator PUF evaluator: from a challenge, races RESP_BITS RO pairs over a fixed clk-cycle window
//  and assembles a RESP_BITS-wide response, one bit per pair (1 = A faster).

---
 rtl/ro_puf_pkg.sv | 19 +
 rtl/ro_puf_if.sv | 26 ++
 rtl/ro_edge_counter.sv | 38 +++
 rtl/ro_puf_eval.sv | 181 ++++++++++++++++++
 tb/tb_ro_puf_eval.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF evaluator.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        COUNT,
        CMP
    } state_t;

    localparam int SETTLE_CYC = 2;

    // RO index of pair k relative to a base index; n is a power of two so this is a plain wrap.
    function automatic int pair_idx(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/ro_puf_if.sv
// Request/response bundle between the PUF evaluator and its host.
interface ro_puf_if #(
    parameter int SEL_W     = 5,
    parameter int CW        = 16,
    parameter int RESP_BITS = 8
);
    logic                   start;
    logic [2*SEL_W-1:0]     challenge;
    logic                   busy;
    logic                   valid;
    logic [RESP_BITS-1:0]   response;
    logic                   tie;
    logic                   sat;
    logic [CW-1:0]          cnt_a_dbg;
    logic [CW-1:0]          cnt_b_dbg;

    modport master (
        output start, challenge,
        input  busy, valid, response, tie, sat, cnt_a_dbg, cnt_b_dbg
    );

    modport slave (
        input  start, challenge,
        output busy, valid, response, tie, sat, cnt_a_dbg, cnt_b_dbg
    );
endinterface

// File: rtl/ro_edge_counter.sv
// Synchronises one RO, detects its rising edges and counts them into a saturating counter.
module ro_edge_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ro,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          sat
);
    logic sync1;
    logic sync2;
    logic sync2_d;
    logic rise;

    assign rise = sync2 & ~sync2_d;
    assign sat  = &cnt;

    // clr wins over a coincident edge so a fresh window never starts at 1.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= ro;
            sync2   <= sync1;
            sync2_d <= sync2;
            if (clr)
                cnt <= '0;
            else if (en && rise && !sat)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator: races RESP_BITS RO pairs and assembles a response.
// Define RO_PUF_MAJORITY_EN to decide each bit by a 3-round majority vote.
module ro_puf_eval
    import ro_puf_pkg::*;
#(
    parameter int N_RO      = 32,
    parameter int SEL_W     = 5,
    parameter int CW        = 16,
    parameter int WIN_CYC   = 1024,
    parameter int RESP_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_RO-1:0] ro_i,
    ro_puf_if.slave         bus
);
    localparam int WW = $clog2(WIN_CYC + 1);
    localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    state_t                 state;
    logic [WW-1:0]          win_cnt;
    logic [KW-1:0]          k;
    logic [SEL_W-1:0]       idx_a;
    logic [SEL_W-1:0]       idx_b;
    logic [SEL_W-1:0]       sel_a;
    logic [SEL_W-1:0]       sel_b;
    logic [CW-1:0]          cnt_a;
    logic [CW-1:0]          cnt_b;
    logic                   sat_a;
    logic                   sat_b;
    logic                   a_wins;
    logic                   pair_done;
    logic                   bit_val;

    logic                   busy_q;
    logic                   valid_q;
    logic [RESP_BITS-1:0]   resp_q;
    logic                   tie_q;
    logic                   sat_q;
    logic [CW-1:0]          dbg_a_q;
    logic [CW-1:0]          dbg_b_q;

    assign sel_a  = SEL_W'(pair_idx(int'(idx_a), int'(k), N_RO));
    assign sel_b  = SEL_W'(pair_idx(int'(idx_b), int'(k), N_RO));
    assign a_wins = (cnt_a > cnt_b);

`ifdef RO_PUF_MAJORITY_EN
    logic [1:0] round;
    logic [1:0] votes;

    // A tie votes 0; the final round adds its own vote before thresholding.
    assign pair_done = (round == 2'd2);
    assign bit_val   = ((votes + {1'b0, a_wins}) >= 2'd2);
`else
    assign pair_done = 1'b1;
    assign bit_val   = a_wins;
`endif

    ro_edge_counter #(.CW(CW)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_i[sel_a]),
        .clr   (state == CLEAR),
        .en    (state == COUNT),
        .cnt   (cnt_a),
        .sat   (sat_a)
    );

    ro_edge_counter #(.CW(CW)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_i[sel_b]),
        .clr   (state == CLEAR),
        .en    (state == COUNT),
        .cnt   (cnt_b),
        .sat   (sat_b)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= IDLE;
            win_cnt <= '0;
            k       <= '0;
            idx_a   <= '0;
            idx_b   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            resp_q  <= '0;
            tie_q   <= 1'b0;
            sat_q   <= 1'b0;
            dbg_a_q <= '0;
            dbg_b_q <= '0;
`ifdef RO_PUF_MAJORITY_EN
            round   <= '0;
            votes   <= '0;
`endif
        end else if (state != IDLE && !ena) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && ena) begin
                        valid_q <= 1'b0;
                        tie_q   <= 1'b0;
                        sat_q   <= 1'b0;
                        resp_q  <= '0;
                        busy_q  <= 1'b1;
                        idx_a   <= bus.challenge[SEL_W-1:0];
                        idx_b   <= bus.challenge[2*SEL_W-1:SEL_W];
                        k       <= '0;
`ifdef RO_PUF_MAJORITY_EN
                        round   <= '0;
                        votes   <= '0;
`endif
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    win_cnt <= WW'(SETTLE_CYC - 1);
                    state   <= SETTLE;
                end
                SETTLE: begin
                    if (win_cnt == '0) begin
                        win_cnt <= WW'(WIN_CYC - 1);
                        state   <= COUNT;
                    end else begin
                        win_cnt <= win_cnt - 1'b1;
                    end
                end
                COUNT: begin
                    if (win_cnt == '0)
                        state <= CMP;
                    else
                        win_cnt <= win_cnt - 1'b1;
                end
                CMP: begin
                    dbg_a_q <= cnt_a;
                    dbg_b_q <= cnt_b;
                    if (cnt_a == cnt_b)
                        tie_q <= 1'b1;
                    if (sat_a || sat_b)
                        sat_q <= 1'b1;
                    if (!pair_done) begin
`ifdef RO_PUF_MAJORITY_EN
                        round <= round + 1'b1;
                        votes <= votes + {1'b0, a_wins};
`endif
                        state <= CLEAR;
                    end else begin
                        for (int i = 0; i < RESP_BITS; i++)
                            if (int'(k) == i)
                                resp_q[i] <= bit_val;
`ifdef RO_PUF_MAJORITY_EN
                        round <= '0;
                        votes <= '0;
`endif
                        if (int'(k) == RESP_BITS - 1) begin
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            k     <= k + 1'b1;
                            state <= CLEAR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.response  = resp_q;
    assign bus.tie       = tie_q;
    assign bus.sat       = sat_q;
    assign bus.cnt_a_dbg = dbg_a_q;
    assign bus.cnt_b_dbg = dbg_b_q;
endmodule

// File: tb/tb_ro_puf_eval.sv
// Directed bench for ro_puf_eval: an 8-bit evaluator, a 1-bit evaluator and a 1-bit evaluator with 4-bit counters.
module tb_ro_puf_eval;
    localparam int WIN     = 64;
    localparam int PER_BIT = WIN + 4;
`ifdef RO_PUF_MAJORITY_EN
    localparam int ROUNDS     = 3;
    localparam int ABORT_RESP = 0;
`else
    localparam int ROUNDS     = 1;
    localparam int ABORT_RESP = 1;
`endif
    localparam int LAT1  = ROUNDS * PER_BIT;
    localparam int LAT8  = 8 * LAT1;
    localparam int LIMIT = 4000;

    logic        clk;
    logic        rst_n;
    logic        ena;
    wire  [31:0] ro;
    int          checks;
    int          errors;
    int          cyc;

    typedef struct {
        int         a;
        int         b;
        logic [7:0] resp;
        logic       tie;
        int         dbg_a;
        int         dbg_b;
    } vec_t;

    vec_t vecs[5];

    ro_puf_if #(.SEL_W(5), .CW(16), .RESP_BITS(8)) if8();
    ro_puf_if #(.SEL_W(5), .CW(16), .RESP_BITS(1)) if1();
    ro_puf_if #(.SEL_W(5), .CW(4),  .RESP_BITS(1)) ifs();

    ro_puf_eval #(.N_RO(32), .SEL_W(5), .CW(16), .WIN_CYC(WIN), .RESP_BITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ro_i(ro), .bus(if8.slave)
    );
    ro_puf_eval #(.N_RO(32), .SEL_W(5), .CW(16), .WIN_CYC(WIN), .RESP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ro_i(ro), .bus(if1.slave)
    );
    ro_puf_eval #(.N_RO(32), .SEL_W(5), .CW(4), .WIN_CYC(WIN), .RESP_BITS(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ro_i(ro), .bus(ifs.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RO half-periods; toggles land on multiples of 10, clock rises at 5 mod 10, so counts are exact.
    function automatic int ro_half(input int i);
        case (i)
            0:       return 40;
            1:       return 20;
            2:       return 80;
            3:       return 20;
            4:       return 40;
            5:       return 40;
            6:       return 20;
            7:       return 80;
            31:      return 20;
            default: return 60;
        endcase
    endfunction

    for (genvar g = 0; g < 32; g++) begin : g_ro
        logic r;
        initial begin
            r = 1'b0;
            forever #(ro_half(g)) r = ~r;
        end
        assign ro[g] = r;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input longint actual, input longint lo, input longint hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    function automatic logic valid_of(input int sel);
        case (sel)
            0:       return if8.valid;
            1:       return if1.valid;
            default: return ifs.valid;
        endcase
    endfunction

    // Presents one start pulse; returns #1 after the accepting edge.
    task automatic startEval(input int sel, input int a, input int b);
        @(negedge clk);
        case (sel)
            0:       begin if8.challenge = {5'(b), 5'(a)}; if8.start = 1'b1; end
            1:       begin if1.challenge = {5'(b), 5'(a)}; if1.start = 1'b1; end
            default: begin ifs.challenge = {5'(b), 5'(a)}; ifs.start = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        if1.start = 1'b0;
        ifs.start = 1'b0;
    endtask

    task automatic applyStimulus(input int sel, input int a, input int b, output int cycles);
        startEval(sel, a, b);
        cycles = 0;
        while (!valid_of(sel) && cycles < LIMIT) begin
            @(posedge clk);
            cycles++;
            #1;
        end
        if (!valid_of(sel)) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout dut%0d: valid not seen within %0d cycles", sel, LIMIT);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        ena    = 1'b1;
        if8.start = 1'b0; if8.challenge = '0;
        if1.start = 1'b0; if1.challenge = '0;
        ifs.start = 1'b0; ifs.challenge = '0;

        vecs[0] = '{31, 0,  8'h95, 1'b1, 16, 4};
        vecs[1] = '{3,  5,  8'h0D, 1'b1, 5,  5};
        vecs[2] = '{5,  3,  8'h12, 1'b1, 5,  5};
        vecs[3] = '{7,  7,  8'h00, 1'b1, 5,  5};
        vecs[4] = '{0,  31, 8'h4A, 1'b1, 4,  16};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy",     if8.busy,      0);
        checkOutput("reset_valid",    if8.valid,     0);
        checkOutput("reset_response", if8.response,  0);
        checkOutput("reset_tie",      if8.tie,       0);
        checkOutput("reset_sat",      if8.sat,       0);
        checkOutput("reset_cnt_a",    if8.cnt_a_dbg, 0);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(posedge clk);

        // Single pair, A twice as fast as B.
        applyStimulus(1, 3, 5, cyc);
        checkOutput("r1_latency",  cyc,          LAT1);
        checkOutput("r1_response", if1.response, 1);
        checkOutput("r1_tie",      if1.tie,      0);
        checkOutput("r1_sat",      if1.sat,      0);
        checkOutput("r1_busy",     if1.busy,     0);
        checkRange ("r1_cnt_a",    if1.cnt_a_dbg, 15, 17);
        checkRange ("r1_cnt_b",    if1.cnt_b_dbg, 7, 9);

        applyStimulus(1, 5, 3, cyc);
        checkOutput("swap_latency",  cyc,          LAT1);
        checkOutput("swap_response", if1.response, 0);
        checkOutput("swap_tie",      if1.tie,      0);

        // 4-bit counters: the fast RO exceeds 15 edges in the window.
        applyStimulus(2, 3, 5, cyc);
        checkOutput("satc_cnt_a",    ifs.cnt_a_dbg, 15);
        checkOutput("satc_sat",      ifs.sat,       1);
        checkOutput("satc_response", ifs.response,  1);
        checkRange ("satc_cnt_b",    ifs.cnt_b_dbg, 7, 9);

        // Reset in the middle of an evaluation wipes sticky flags and debug counts.
        startEval(0, 7, 7);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("pre_reset_tie",  if8.tie,  1);
        checkOutput("pre_reset_busy", if8.busy, 1);
        rst_n = 1'b1;
        #1;
        checkOutput("midreset_busy",  if8.busy,      0);
        checkOutput("midreset_tie",   if8.tie,       0);
        checkOutput("midreset_valid", if8.valid,     0);
        checkOutput("midreset_cnt_a", if8.cnt_a_dbg, 0);
        checkOutput("midreset_cnt_b", if8.cnt_b_dbg, 0);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, vecs[i].a, vecs[i].b, cyc);
            $display("[TB] vector %0d a=%0d b=%0d response=%h", i, vecs[i].a, vecs[i].b, if8.response);
            checkOutput($sformatf("vec%0d_latency", i),  cyc,          LAT8);
            checkOutput($sformatf("vec%0d_response", i), if8.response, vecs[i].resp);
            checkOutput($sformatf("vec%0d_tie", i),      if8.tie,      vecs[i].tie);
            checkOutput($sformatf("vec%0d_sat", i),      if8.sat,      0);
            checkOutput($sformatf("vec%0d_busy", i),     if8.busy,     0);
            checkRange ($sformatf("vec%0d_cnt_a", i),    if8.cnt_a_dbg, vecs[i].dbg_a - 1, vecs[i].dbg_a + 1);
            checkRange ($sformatf("vec%0d_cnt_b", i),    if8.cnt_b_dbg, vecs[i].dbg_b - 1, vecs[i].dbg_b + 1);
        end

        // A start pulse while busy is neither honoured nor queued.
        startEval(0, 3, 5);
        cyc = 0;
        repeat (50) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        if8.challenge = {5'd7, 5'd7};
        if8.start     = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        if8.start = 1'b0;
        while (!if8.valid && cyc < LIMIT) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        checkOutput("ignore_latency",  cyc,          LAT8);
        checkOutput("ignore_response", if8.response, 8'h0D);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ignore_noqueue_busy",  if8.busy,  0);
        checkOutput("ignore_noqueue_valid", if8.valid, 1);

        // Dropping ena mid-run aborts and keeps the bits completed so far.
        startEval(0, 3, 5);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("abort_pre_busy", if8.busy, 1);
        ena = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_busy",     if8.busy,     0);
        checkOutput("abort_valid",    if8.valid,    0);
        checkOutput("abort_response", if8.response, ABORT_RESP);
        ena = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        checkOutput("abort_idle_valid", if8.valid, 0);
        checkOutput("abort_idle_busy",  if8.busy,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
